// File: rtl/i2s_streamer_pkg.sv
// Shared types and defaults for the LED panel serial transmitter.
// Optional build macro: I2S_STREAMER_UNDERRUN_FILL_EN (zero-word fill on underrun).
package i2s_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_WORD_W      = 8;
  localparam int DEF_FRAME_WORDS = 512;
  localparam int DEF_GAP_BITS    = 4;

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_streamer_if.sv
// Ready/valid pixel word stream feeding the serial transmitter.
interface i2s_streamer_if #(
  parameter int WORD_W = i2s_streamer_pkg::DEF_WORD_W
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_clk_gen.sv
// Serial clock generator: CLK_DIV cycles per half-period, low half first,
// with strobes marking the edges at which i2s_clk rises or falls.
module i2s_clk_gen
  import i2s_streamer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic i2s_clk,
  output logic tick_fall,
  output logic tick_rise
);
  localparam int PW = cnt_w(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase;
  logic          half_end;

  assign half_end  = run && (phase == PH_LAST);
  assign tick_rise = half_end && !i2s_clk;
  assign tick_fall = half_end && i2s_clk;

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      phase   <= '0;
      i2s_clk <= 1'b0;
    end else if (half_end) begin
      phase   <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_streamer.sv
// Frame-based MSB-first serializer with a one-word holding buffer.
// Build macro I2S_STREAMER_UNDERRUN_FILL_EN replaces the underrun stall by a zero word.
module i2s_streamer
  import i2s_streamer_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int GAP_BITS    = DEF_GAP_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  i2s_streamer_if.slave  in_if,
  output logic           i2s_clk,
  output logic           i2s_data,
  output logic           busy,
  output logic           frame_done,
  output logic           underrun
);
  localparam int BW      = cnt_w(WORD_W);
  localparam int WW      = cnt_w(FRAME_WORDS);
  localparam int GAP_LEN = GAP_BITS * 2 * CLK_DIV;
  localparam int GW      = cnt_w(GAP_LEN);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LEN - 1);

  state_t            state;
  logic [WORD_W-1:0] buf_word;
  logic [WORD_W-1:0] shreg;
  logic              buf_full;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     word_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              run;
  logic              tick_fall;
  logic              tick_rise;
  logic              transfer;
  logic              word_end;
  logic              load;

  assign run            = (state == SHIFT);
  assign in_if.in_ready = !buf_full;
  assign transfer       = in_if.in_valid && !buf_full;
  assign word_end       = tick_fall && (bit_cnt == BIT_LAST);

  i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .i2s_clk   (i2s_clk),
    .tick_fall (tick_fall),
    .tick_rise (tick_rise)
  );

  // The shifter takes the buffered word only at these points.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = enable && buf_full;
      SHIFT:   load = word_end && (word_cnt != WORD_LAST) && buf_full;
      STALL:   load = buf_full;
      GAP:     load = (gap_cnt == GAP_LAST) && enable && buf_full;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_word <= '0;
    end else if (transfer) begin
      buf_full <= 1'b1;
      buf_word <= in_if.in_data;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      i2s_data   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      // Shift after the receiver has sampled, so the next bit is ready at the fall.
      if (tick_rise) shreg <= shreg << 1;
      if (load) begin
        state    <= SHIFT;
        busy     <= 1'b1;
        shreg    <= buf_word;
        i2s_data <= buf_word[WORD_W-1];
        bit_cnt  <= '0;
        if (state == SHIFT) word_cnt <= word_cnt + 1'b1;
        else if (state != STALL) word_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            i2s_data <= 1'b0;
            busy     <= 1'b0;
          end
          SHIFT: begin
            if (tick_fall) begin
              if (bit_cnt != BIT_LAST) begin
                bit_cnt  <= bit_cnt + 1'b1;
                i2s_data <= shreg[WORD_W-1];
              end else if (word_cnt == WORD_LAST) begin
                state      <= GAP;
                gap_cnt    <= '0;
                i2s_data   <= 1'b0;
                frame_done <= 1'b1;
              end else begin
                underrun <= 1'b1;
                word_cnt <= word_cnt + 1'b1;
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
                shreg    <= '0;
                i2s_data <= 1'b0;
                bit_cnt  <= '0;
`else
                state    <= STALL;
                busy     <= 1'b0;
`endif
              end
            end
          end
          STALL: begin
            busy <= 1'b0;
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_streamer.sv
// Randomized bench: a serial receiver model rebuilds words at i2s_clk rising
// edges and compares them against the queue of accepted input words.
module tb_i2s_streamer;
  localparam int CLK_DIV     = 2;
  localparam int WORD_W      = 8;
  localparam int FRAME_WORDS = 2;
  localparam int GAP_BITS    = 4;
  localparam int GAP_LEN     = GAP_BITS * 2 * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic i2s_clk, i2s_data, busy, frame_done, underrun;

  i2s_streamer_if #(.WORD_W(WORD_W)) in_if ();

  i2s_streamer #(
    .CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .FRAME_WORDS(FRAME_WORDS), .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_if(in_if),
    .i2s_clk(i2s_clk), .i2s_data(i2s_data), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Receiver / scoreboard state
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] rx_word = '0;
  logic [WORD_W-1:0] pend_data = '0;
  logic [WORD_W-1:0] exp_word;
  logic pend_xfer = 1'b0;
  logic prev_clk = 1'b0;
  logic prev_data = 1'b0;
  logic gap_bad = 1'b0;
  int rx_bits = 0;
  int words_in_frame = 0;
  int n_frames = 0;
  int n_rises = 0;
  int n_xfer = 0;
  int n_underrun = 0;
  int gap_left = 0;
  int last_rise = -1000;
  int last_change = -1000;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      rx_bits = 0;
      words_in_frame = 0;
      pend_xfer = 1'b0;
      gap_left = 0;
      last_rise = -1000;
      last_change = -1000;
    end else begin
      if (underrun) begin
        n_underrun++;
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
        exp_q.push_back('0);
`endif
      end
      // A transfer seen before this edge has now happened; buffer must read full.
      if (pend_xfer) begin
        exp_q.push_back(pend_data);
        n_xfer++;
        chk("ready_low_after_xfer", in_if.in_ready, 1'b0);
      end
      pend_xfer = in_if.in_valid && in_if.in_ready;
      pend_data = in_if.in_data;
      if (i2s_data !== prev_data) begin
        chk("data_hold", (cyc - last_rise) >= CLK_DIV, 1'b1);
        last_change = cyc;
      end
      if (i2s_clk && !prev_clk) begin
        n_rises++;
        last_rise = cyc;
        chk("data_setup", (cyc - last_change) >= CLK_DIV, 1'b1);
        chk("busy_shift", busy, 1'b1);
        rx_word = {rx_word[WORD_W-2:0], i2s_data};
        rx_bits++;
        if (rx_bits == WORD_W) begin
          rx_bits = 0;
          chk("rx_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            $display("rx word %02h (expected %02h) cycle %0d", rx_word, exp_word, cyc);
            chk("rx_word", rx_word, exp_word);
          end
          words_in_frame++;
        end
      end
      if (gap_left > 0) begin
        if (i2s_clk || i2s_data) gap_bad = 1'b1;
        gap_left--;
        if (gap_left == 0) chk("gap_idle", gap_bad, 1'b0);
      end
      if (frame_done) begin
        chk("frame_len", words_in_frame, FRAME_WORDS);
        words_in_frame = 0;
        n_frames++;
        gap_left = GAP_LEN - 1;
        gap_bad = i2s_clk || i2s_data;
      end
    end
    prev_clk = i2s_clk;
    prev_data = i2s_data;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WORD_W-1:0] w);
    int guard = 0;
    in_if.in_data = w;
    in_if.in_valid = 1'b1;
    @(negedge clk);
    while (!in_if.in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("push_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int guard = 0;
    while (n_frames < target && guard < 5000) begin
      step(1);
      guard++;
    end
    chk("frame_timeout", n_frames >= target, 1'b1);
  endtask

  task automatic check_reset_values();
    chk("rst_i2s_clk", i2s_clk, 1'b0);
    chk("rst_i2s_data", i2s_data, 1'b0);
    chk("rst_in_ready", in_if.in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r0, u0, x0, t0, first_rise, guard;
    logic hi;
    in_if.in_valid = 1'b0;
    in_if.in_data = '0;
    step(3);
    check_reset_values();
    rst_n = 1'b1;
    step(2);
    chk("idle_busy_after_reset", busy, 1'b0);

    // Basic frame 0xA5, 0x3C with latency from IDLE
    enable = 1'b1;
    push_word(8'hA5);
    t0 = cyc;
    step(1);
    chk("msb_latency", i2s_data, 1'b1);
    chk("clk_low_first_half", i2s_clk, 1'b0);
    guard = 0;
    while (!i2s_clk && guard < 50) begin step(1); guard++; end
    chk("first_rise", cyc - t0, CLK_DIV + 1);
    first_rise = cyc;
    push_word(8'h3C);
    wait_frames(1);
    chk("frame_span", last_rise - first_rise, (FRAME_WORDS * WORD_W - 1) * 2 * CLK_DIV);
    step(GAP_LEN + 2);
    chk("idle_after_gap", busy, 1'b0);

    // Randomized words with random pacing
    n0 = n_frames;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < FRAME_WORDS; w++) begin
        step($urandom_range(0, 3));
        push_word(WORD_W'($urandom_range(0, 255)));
      end
    end
    wait_frames(n0 + 3);
    step(GAP_LEN + 4);

    // Underrun: second word withheld
    n0 = n_frames;
    u0 = n_underrun;
    push_word(WORD_W'($urandom_range(0, 255)));
    guard = 0;
    while (n_underrun == u0 && guard < 200) begin step(1); guard++; end
    chk("underrun_seen", n_underrun - u0, 1);
`ifdef I2S_STREAMER_UNDERRUN_FILL_EN
    wait_frames(n0 + 1);
    step(GAP_LEN + 4);
    push_word(WORD_W'($urandom_range(0, 255)));
    push_word(WORD_W'($urandom_range(0, 255)));
    wait_frames(n0 + 2);
`else
    hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      hi = hi | i2s_clk;
    end
    chk("stall_clk_low", hi, 1'b0);
    push_word(WORD_W'($urandom_range(0, 255)));
    wait_frames(n0 + 1);
`endif
    chk("underrun_once", n_underrun - u0, 1);
    step(GAP_LEN + 4);

    // Enable drop after the 3rd bit of word 0
    n0 = n_frames;
    r0 = n_rises;
    push_word(WORD_W'($urandom_range(0, 255)));
    guard = 0;
    while (n_rises < r0 + 3 && guard < 100) begin step(1); guard++; end
    enable = 1'b0;
    push_word(WORD_W'($urandom_range(0, 255)));
    wait_frames(n0 + 1);
    chk("drop_full_frame", n_rises - r0, FRAME_WORDS * WORD_W);
    step(GAP_LEN + 4);
    chk("drop_idle_busy", busy, 1'b0);
    r0 = n_rises;
    push_word(WORD_W'($urandom_range(0, 255)));
    step(40);
    chk("disabled_no_rise", n_rises - r0, 0);
    chk("disabled_busy", busy, 1'b0);
    chk("disabled_buffer_held", in_if.in_ready, 1'b0);
    enable = 1'b1;
    push_word(WORD_W'($urandom_range(0, 255)));
    wait_frames(n0 + 2);
    step(GAP_LEN + 4);

    // Reset in the middle of word 1, then a fresh frame
    push_word(WORD_W'($urandom_range(0, 255)));
    push_word(WORD_W'($urandom_range(0, 255)));
    guard = 0;
    while (words_in_frame < 1 && guard < 200) begin step(1); guard++; end
    step(10);
    rst_n = 1'b0;
    step(1);
    check_reset_values();
    step(1);
    rst_n = 1'b1;
    n0 = n_frames;
    push_word(WORD_W'($urandom_range(0, 255)));
    push_word(WORD_W'($urandom_range(0, 255)));
    wait_frames(n0 + 1);
    step(GAP_LEN + 4);

    // Backpressure: valid held high across 4 frames
    n0 = n_frames;
    x0 = n_xfer;
    in_if.in_valid = 1'b1;
    for (int i = 0; i < 4 * FRAME_WORDS; i++) begin
      in_if.in_data = WORD_W'($urandom_range(0, 255));
      guard = 0;
      @(negedge clk);
      while (!in_if.in_ready && guard < 2000) begin @(negedge clk); guard++; end
      @(posedge clk);
      #1;
    end
    in_if.in_valid = 1'b0;
    wait_frames(n0 + 4);
    chk("bp_transfers", n_xfer - x0, 4 * FRAME_WORDS);
    chk("bp_queue_drained", exp_q.size(), 0);
    step(GAP_LEN + 4);
    chk("final_idle", busy, 1'b0);
    chk("underrun_total", n_underrun, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
